fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-operand forwarding unit in the EX stage of the pipelined core.
- Generalises to NUM_SRC source operands and NUM_STG downstream forwarding stages, with registered per-operand forward selects.
- Adds load-use hazard detection with a multi-cycle stall FSM.
- Adds saturating stall and forward event counters for performance profiling.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- NUM_STG, 2, forwarding stages; index 0 is nearest (EX/MEM), 1 is next (MEM/WB), and so on.
- SEL_W, $clog2(NUM_STG+1), width of each forward select field.
- LOAD_STALL, 1, stall cycles per load-use hazard; must be ≥1.
- CNT_W, 16, event counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Src_ID_EX  in  NUM_SRC*REG_AW  source register numbers of the instruction in EX; operand i at bits [i*REG_AW +: REG_AW].
- Src_IF_ID  in  NUM_SRC*REG_AW  source register numbers of the instruction in ID.
- RegWrite_Stg  in  NUM_STG  write-enable of each downstream stage.
- Rd_Stg  in  NUM_STG*REG_AW  destination register of each downstream stage; stage k at [k*REG_AW +: REG_AW].
- MemRead_ID_EX  in  1  instruction in EX is a load.
- Rd_ID_EX  in  REG_AW  destination register of the instruction in EX.
- Cnt_Clr  in  1  synchronous clear of both counters.
- Forward_Sel  out  NUM_SRC*SEL_W  registered per-operand select; 0 = register file, k+1 = stage k.
- Stall  out  1  hold PC and IF/ID.
- Flush_ID_EX  out  1  insert bubble into ID/EX; always equal to Stall.
- Stall_Count  out  CNT_W  cycles with Stall high.
- Fwd_Count  out  CNT_W  cycles in which any Forward_Sel field loaded nonzero.

Behaviour:
- Reset, asynchronous:
  - Forward_Sel=0, FSM=IDLE, remaining-stall counter=0, Stall_Count=0, Fwd_Count=0.
  - Stall and Flush_ID_EX are forced 0 while Reset is high.
- Forward select per operand i, evaluated combinationally and loaded at each rising Clk:
  - Choose the lowest k with RegWrite_Stg[k]=1, Rd_Stg[k]!=0 and Rd_Stg[k]==Src_ID_EX[i]; the field value is k+1.
  - If no stage matches, the field is 0.
  - Priority: nearest stage wins when several stages match.
  - Register 0 never forwards.
  - Latency: exactly one cycle; Forward_Sel after edge n reflects inputs sampled at edge n.
- Hazard detect (hz), combinational:
  - hz = MemRead_ID_EX && Rd_ID_EX!=0 && Rd_ID_EX equals any Src_IF_ID operand.
- FSM states: IDLE, STALL.
  - IDLE:
    - Stall = hz, same cycle (Mealy output).
    - If hz and LOAD_STALL>1: go to STALL, remaining = LOAD_STALL-1.
    - If hz and LOAD_STALL=1: stay in IDLE.
  - STALL:
    - Stall = 1.
    - Each cycle, remaining decrements; when remaining==1 at an edge, go to IDLE.
    - hz is ignored while in STALL; there is no re-trigger or extension.
  - Net effect: a detection at cycle t gives Stall high for exactly cycles t .. t+LOAD_STALL-1.
  - After returning to IDLE, a still-present hz re-triggers a new stall sequence immediately.
- Counters:
  - Stall_Count increments on each edge where Stall=1.
  - Fwd_Count increments on each edge where any newly loaded Forward_Sel field is nonzero.
  - Both saturate at all-ones with no wrap.
  - Cnt_Clr has priority over increment; a cleared counter reads 0 on the next cycle.
- Reset mid-stall: FSM returns to IDLE at once and Stall drops asynchronously.
- Widths: all equality compares are full REG_AW bits; no partial matching.

Test Plan:
- Defaults, RegWrite_Stg=2'b11, Rd_Stg stage0=5, stage1=5, Src_ID_EX op0=5 -> next cycle op0 select=1 (stage 0 wins); Fwd_Count=1.
- RegWrite_Stg=2'b10, Rd stage1=7, op1=7, op0=3 -> op1 select=2, op0 select=0. Repeat with Rd=0 and Src=0 -> all selects 0, Fwd_Count unchanged.
- LOAD_STALL=3: MemRead_ID_EX=1, Rd_ID_EX=9, Src_IF_ID op1=9 for one cycle at t -> Stall and Flush_ID_EX high on cycles t, t+1, t+2, low at t+3; Stall_Count=3.
- LOAD_STALL=3, hz held high continuously for 5 cycles -> Stall high on all 5 cycles (cycles 0-2 first sequence, cycles 3-4 second sequence).
- Reset asserted asynchronously at stall cycle 2 of 3 -> Stall=0 immediately, Forward_Sel=0, both counters 0; after release with no hz, Stall stays 0.
- CNT_W=2, 5 consecutive forwarding cycles -> Fwd_Count sticks at 3. Cnt_Clr pulse coincident with a forwarding cycle -> reads 0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the EX stage.
// Produces registered per-operand forward selects over NUM_STG downstream
// stages, detects load-use hazards against the instruction in ID, holds the
// front end for LOAD_STALL cycles per hazard, and keeps saturating event
// counters for stalls and forwards.
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STG    = 2,
  parameter int SEL_W      = $clog2(NUM_STG + 1),
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_SRC*REG_AW-1:0]  Src_ID_EX,
  input  logic [NUM_SRC*REG_AW-1:0]  Src_IF_ID,
  input  logic [NUM_STG-1:0]         RegWrite_Stg,
  input  logic [NUM_STG*REG_AW-1:0]  Rd_Stg,
  input  logic                       MemRead_ID_EX,
  input  logic [REG_AW-1:0]          Rd_ID_EX,
  input  logic                       Cnt_Clr,
  output logic [NUM_SRC*SEL_W-1:0]   Forward_Sel,
  output logic                       Stall,
  output logic                       Flush_ID_EX,
  output logic [CNT_W-1:0]           Stall_Count,
  output logic [CNT_W-1:0]           Fwd_Count
);

  // Wide enough to hold LOAD_STALL-1 and never zero bits wide.
  localparam int REM_W = $clog2(LOAD_STALL + 1);

  typedef enum logic {
    S_IDLE,
    S_STALL
  } state_e;

  state_e                     state_q;
  logic [REM_W-1:0]           remain_q;
  logic [NUM_SRC*SEL_W-1:0]   fwdSel_d;
  logic [NUM_SRC*SEL_W-1:0]   fwdSel_q;
  logic                       fwdAny;
  logic                       srcMatch;
  logic                       hz;
  logic [CNT_W-1:0]           stallCnt_d;
  logic [CNT_W-1:0]           stallCnt_q;
  logic [CNT_W-1:0]           fwdCnt_d;
  logic [CNT_W-1:0]           fwdCnt_q;

  // Per-operand select: walk from the farthest stage inward so the nearest
  // matching stage is the last writer and therefore wins.
  always_comb begin
    fwdSel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STG - 1; k >= 0; k--) begin
        if (RegWrite_Stg[k] &&
            (Rd_Stg[k*REG_AW +: REG_AW] != '0) &&
            (Rd_Stg[k*REG_AW +: REG_AW] == Src_ID_EX[i*REG_AW +: REG_AW])) begin
          fwdSel_d[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // A field is nonzero exactly when some bit in it is set.
  assign fwdAny = |fwdSel_d;

  // Load-use detection: the load in EX writes a register the ID instruction reads.
  always_comb begin
    srcMatch = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Src_IF_ID[i*REG_AW +: REG_AW] == Rd_ID_EX) begin
        srcMatch = 1'b1;
      end
    end
  end

  assign hz = MemRead_ID_EX && (Rd_ID_EX != '0) && srcMatch;

  // Stall is Mealy in IDLE and forced low while reset is held.
  assign Stall       = !Reset && ((state_q == S_STALL) || hz);
  assign Flush_ID_EX = Stall;

  // Stall sequencer: the detection cycle is the first stall cycle, STALL
  // covers the remaining LOAD_STALL-1 cycles and ignores further hazards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hz && (LOAD_STALL > 1)) begin
            state_q  <= S_STALL;
            remain_q <= REM_W'(LOAD_STALL - 1);
          end
        end
        S_STALL: begin
          if (remain_q == REM_W'(1)) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
          end else begin
            remain_q <= remain_q - 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          remain_q <= '0;
        end
      endcase
    end
  end

  // Saturating event counters; clear takes priority over counting.
  always_comb begin
    stallCnt_d = stallCnt_q;
    fwdCnt_d   = fwdCnt_q;
    if (Cnt_Clr) begin
      stallCnt_d = '0;
      fwdCnt_d   = '0;
    end else begin
      if (Stall && (stallCnt_q != '1)) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
      if (fwdAny && (fwdCnt_q != '1)) begin
        fwdCnt_d = fwdCnt_q + 1'b1;
      end
    end
  end

  // Register forward selects and counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fwdSel_q   <= '0;
      stallCnt_q <= '0;
      fwdCnt_q   <= '0;
    end else begin
      fwdSel_q   <= fwdSel_d;
      stallCnt_q <= stallCnt_d;
      fwdCnt_q   <= fwdCnt_d;
    end
  end

  assign Forward_Sel = fwdSel_q;
  assign Stall_Count = stallCnt_q;
  assign Fwd_Count   = fwdCnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances share one stimulus stream,
// A with a three-cycle load stall and 16-bit counters, B with a one-cycle
// load stall and 2-bit counters so saturation is reachable quickly.
module tb_fwd_hazard_unit;

  logic        Clk;
  logic        Reset;
  logic [9:0]  srcEx;
  logic [9:0]  srcId;
  logic [1:0]  rw;
  logic [9:0]  rd;
  logic        memRd;
  logic [4:0]  rdEx;
  logic        cntClr;

  logic [3:0]  selA, selB;
  logic        stallA, stallB, flushA, flushB;
  logic [15:0] stallCntA, fwdCntA;
  logic [1:0]  stallCntB, fwdCntB;

  int nVectors    = 0;
  int nMiscompares = 0;

  fwd_hazard_unit #(.LOAD_STALL(3), .CNT_W(16)) dutA (
    .Clk(Clk), .Reset(Reset), .Src_ID_EX(srcEx), .Src_IF_ID(srcId),
    .RegWrite_Stg(rw), .Rd_Stg(rd), .MemRead_ID_EX(memRd), .Rd_ID_EX(rdEx),
    .Cnt_Clr(cntClr), .Forward_Sel(selA), .Stall(stallA), .Flush_ID_EX(flushA),
    .Stall_Count(stallCntA), .Fwd_Count(fwdCntA)
  );

  fwd_hazard_unit #(.LOAD_STALL(1), .CNT_W(2)) dutB (
    .Clk(Clk), .Reset(Reset), .Src_ID_EX(srcEx), .Src_IF_ID(srcId),
    .RegWrite_Stg(rw), .Rd_Stg(rd), .MemRead_ID_EX(memRd), .Rd_ID_EX(rdEx),
    .Cnt_Clr(cntClr), .Forward_Sel(selB), .Stall(stallB), .Flush_ID_EX(flushB),
    .Stall_Count(stallCntB), .Fwd_Count(fwdCntB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- behavioural model ----------------
  int          stallLen [2] = '{3, 1};
  int          cntMax   [2] = '{65535, 3};
  int          stallEnd [2];
  int          mStallCnt[2];
  int          mFwdCnt  [2];
  logic [3:0]  mSel;
  int          cyc = 0;

  // Nearest enabled stage writing the operand's nonzero register supplies it.
  function automatic logic [3:0] expSel(input logic [9:0] s, input logic [1:0] w,
                                        input logic [9:0] r);
    logic [3:0] res;
    res = '0;
    for (int i = 0; i < 2; i++) begin
      int f;
      f = 0;
      for (int k = 0; k < 2; k++) begin
        if (f == 0 && w[k] && r[k*5 +: 5] != 0 && r[k*5 +: 5] == s[i*5 +: 5]) f = k + 1;
      end
      res[i*2 +: 2] = 2'(f);
    end
    return res;
  endfunction

  function automatic logic hzOf(input logic m, input logic [4:0] rdx, input logic [9:0] s);
    return m && rdx != 0 && (s[4:0] == rdx || s[9:5] == rdx);
  endfunction

  // A hazard seen at cycle c outside an existing stall window opens the
  // window c .. c+len-1; counters saturate at their maximum.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mSel = '0;
      for (int d = 0; d < 2; d++) begin
        stallEnd[d] = 0; mStallCnt[d] = 0; mFwdCnt[d] = 0;
      end
    end else begin
      logic h;
      logic [3:0] ns;
      h  = hzOf(memRd, rdEx, srcId);
      ns = expSel(srcEx, rw, rd);
      for (int d = 0; d < 2; d++) begin
        logic s;
        s = (cyc < stallEnd[d]) || h;
        if (!(cyc < stallEnd[d]) && h) stallEnd[d] = cyc + stallLen[d];
        if (cntClr) begin
          mStallCnt[d] = 0; mFwdCnt[d] = 0;
        end else begin
          if (s && mStallCnt[d] < cntMax[d]) mStallCnt[d]++;
          if (ns != 0 && mFwdCnt[d] < cntMax[d]) mFwdCnt[d]++;
        end
      end
      mSel = ns;
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model in the middle of every cycle.
  always @(negedge Clk) begin
    logic h;
    logic eA, eB;
    h  = hzOf(memRd, rdEx, srcId);
    eA = !Reset && ((cyc < stallEnd[0]) || h);
    eB = !Reset && ((cyc < stallEnd[1]) || h);
    checkOutput("A.sel",      32'(selA),      32'(mSel));
    checkOutput("B.sel",      32'(selB),      32'(mSel));
    checkOutput("A.stall",    32'(stallA),    32'(eA));
    checkOutput("A.flush",    32'(flushA),    32'(eA));
    checkOutput("B.stall",    32'(stallB),    32'(eB));
    checkOutput("B.flush",    32'(flushB),    32'(eB));
    checkOutput("A.stallCnt", 32'(stallCntA), 32'(mStallCnt[0]));
    checkOutput("A.fwdCnt",   32'(fwdCntA),   32'(mFwdCnt[0]));
    checkOutput("B.stallCnt", 32'(stallCntB), 32'(mStallCnt[1]));
    checkOutput("B.fwdCnt",   32'(fwdCntB),   32'(mFwdCnt[1]));
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [9:0] sEx, input logic [9:0] sId,
                               input logic [1:0] w, input logic [9:0] r,
                               input logic m, input logic [4:0] rdx, input logic clr);
    srcEx = sEx; srcId = sId; rw = w; rd = r; memRd = m; rdEx = rdx; cntClr = clr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
    #1 Reset = 1'b1;
    tick();
    tick();
    checkOutput("rst.selA",      32'(selA),      32'h0);
    checkOutput("rst.stallA",    32'(stallA),    32'h0);
    checkOutput("rst.stallCntA", 32'(stallCntA), 32'h0);
    checkOutput("rst.fwdCntA",   32'(fwdCntA),   32'h0);
    Reset = 1'b0;
    tick();

    // Both stages write r5, op0 reads r5: nearest stage wins.
    applyStimulus({5'd0, 5'd5}, '0, 2'b11, {5'd5, 5'd5}, 1'b0, '0, 1'b0);
    tick();
    checkOutput("lit.sel_prio",  32'(selA),    32'h1);
    checkOutput("lit.fwdCnt1",   32'(fwdCntA), 32'h1);

    // Only stage1 enabled (r7); stage0 holds r3 but is disabled.
    applyStimulus({5'd7, 5'd3}, '0, 2'b10, {5'd7, 5'd3}, 1'b0, '0, 1'b0);
    tick();
    checkOutput("lit.sel_stg1",  32'(selA),    32'h8);
    checkOutput("lit.fwdCnt2",   32'(fwdCntA), 32'h2);

    // Register zero never forwards.
    applyStimulus('0, '0, 2'b11, '0, 1'b0, '0, 1'b0);
    tick();
    checkOutput("lit.sel_r0",    32'(selA),    32'h0);
    checkOutput("lit.fwdCnt_r0", 32'(fwdCntA), 32'h2);

    // Single-cycle load-use hazard on op1 (r9).
    applyStimulus('0, {5'd9, 5'd0}, '0, '0, 1'b1, 5'd9, 1'b0);
    #1;
    checkOutput("lit.stallA_t",  32'(stallA), 32'h1);
    checkOutput("lit.flushA_t",  32'(flushA), 32'h1);
    checkOutput("lit.stallB_t",  32'(stallB), 32'h1);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("lit.stallA_t1", 32'(stallA), 32'h1);
    checkOutput("lit.stallB_t1", 32'(stallB), 32'h0);
    tick();
    checkOutput("lit.stallA_t2", 32'(stallA), 32'h1);
    tick();
    checkOutput("lit.stallA_t3", 32'(stallA), 32'h0);
    checkOutput("lit.stallCntA", 32'(stallCntA), 32'h3);
    checkOutput("lit.stallCntB", 32'(stallCntB), 32'h1);

    // Hazard held for five cycles: back-to-back stall windows.
    for (int n = 0; n < 5; n++) begin
      applyStimulus('0, {5'd0, 5'd9}, '0, '0, 1'b1, 5'd9, 1'b0);
      #1;
      checkOutput("lit.stallA_held", 32'(stallA), 32'h1);
      tick();
    end
    applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
    for (int n = 0; n < 4; n++) tick();

    // Async reset in the second cycle of a three-cycle stall.
    applyStimulus({5'd0, 5'd5}, {5'd9, 5'd0}, 2'b01, {5'd0, 5'd5}, 1'b1, 5'd9, 1'b0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("lit.preRst_stallA", 32'(stallA), 32'h1);
    checkOutput("lit.preRst_selA",   32'(selA),   32'h1);
    #1 Reset = 1'b1;
    #1;
    checkOutput("lit.rst_stallA",    32'(stallA),    32'h0);
    checkOutput("lit.rst_flushA",    32'(flushA),    32'h0);
    checkOutput("lit.rst_selA",      32'(selA),      32'h0);
    checkOutput("lit.rst_stallCntA", 32'(stallCntA), 32'h0);
    checkOutput("lit.rst_fwdCntA",   32'(fwdCntA),   32'h0);
    tick();
    tick();
    Reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("lit.postRst_stallA", 32'(stallA), 32'h0);
    end

    // Five forwarding cycles saturate B's 2-bit counter.
    applyStimulus({5'd0, 5'd5}, '0, 2'b01, {5'd0, 5'd5}, 1'b0, '0, 1'b0);
    for (int n = 0; n < 5; n++) tick();
    checkOutput("lit.fwdCntB_sat", 32'(fwdCntB), 32'h3);
    checkOutput("lit.fwdCntA_5",   32'(fwdCntA), 32'h5);

    // Clear wins over a coincident forwarding event.
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    checkOutput("lit.clr_fwdCntA", 32'(fwdCntA), 32'h0);
    checkOutput("lit.clr_fwdCntB", 32'(fwdCntB), 32'h0);
    tick();
    checkOutput("lit.postClr_fwdCntA", 32'(fwdCntA), 32'h1);

    applyStimulus('0, '0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
